// File: rtl/card_source.sv
// card_source: shuffle counter, six hand slots and registered baccarat scores.
// Ports: CLOCK_50/reset, deal_valid/deal_to/deal_ready, clear_hands, cards, counts, scores, score_valid.
module card_source (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       deal_valid,
  input  logic       deal_to,
  input  logic       clear_hands,
  output logic       deal_ready,
  output logic [3:0] pcard1,
  output logic [3:0] pcard2,
  output logic [3:0] pcard3,
  output logic [3:0] dcard1,
  output logic [3:0] dcard2,
  output logic [3:0] dcard3,
  output logic [1:0] pcount,
  output logic [1:0] dcount,
  output logic [3:0] pscore,
  output logic [3:0] dscore,
  output logic       score_valid
);

  logic [3:0] shuf;
  logic [1:0] sel_cnt;
  logic       accept;
  logic [4:0] psum;
  logic [4:0] dsum;

  // Tens, face cards and empty slots all score zero.
  function automatic logic [4:0] face(
    input logic [3:0] c
  );
    logic [4:0] v;
    v = 5'd0;
    if (c >= 4'd1 && c <= 4'd9)
      v = {1'b0, c};
    return v;
  endfunction

  function automatic logic [3:0] mod10(
    input logic [4:0] s
  );
    logic [4:0] r;
    if (s >= 5'd20)
      r = s - 5'd20;
    else if (s >= 5'd10)
      r = s - 5'd10;
    else
      r = s;
    return r[3:0];
  endfunction

  assign sel_cnt = deal_to ? dcount : pcount;

  assign deal_ready = !reset
                    & !clear_hands
                    & (sel_cnt != 2'd3);

  assign accept = deal_valid & deal_ready;

  assign psum = face(pcard1)
              + face(pcard2)
              + face(pcard3);

  assign dsum = face(dcard1)
              + face(dcard2)
              + face(dcard3);

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      shuf        <= 4'd1;
      pcard1      <= 4'd0;
      pcard2      <= 4'd0;
      pcard3      <= 4'd0;
      dcard1      <= 4'd0;
      dcard2      <= 4'd0;
      dcard3      <= 4'd0;
      pcount      <= 2'd0;
      dcount      <= 2'd0;
      pscore      <= 4'd0;
      dscore      <= 4'd0;
      score_valid <= 1'b1;
    end else begin
      shuf <= (shuf == 4'd13) ? 4'd1
                              : shuf + 4'd1;
      // Scores lag the slots by one edge.
      score_valid <= !(accept | clear_hands);
      if (clear_hands) begin
        pcard1 <= 4'd0;
        pcard2 <= 4'd0;
        pcard3 <= 4'd0;
        dcard1 <= 4'd0;
        dcard2 <= 4'd0;
        dcard3 <= 4'd0;
        pcount <= 2'd0;
        dcount <= 2'd0;
        pscore <= 4'd0;
        dscore <= 4'd0;
      end else begin
        pscore <= mod10(psum);
        dscore <= mod10(dsum);
        if (accept && deal_to) begin
          case (dcount)
            2'd0:    dcard1 <= shuf;
            2'd1:    dcard2 <= shuf;
            default: dcard3 <= shuf;
          endcase
          dcount <= dcount + 2'd1;
        end else if (accept) begin
          case (pcount)
            2'd0:    pcard1 <= shuf;
            2'd1:    pcard2 <= shuf;
            default: pcard3 <= shuf;
          endcase
          pcount <= pcount + 2'd1;
        end
      end
    end
  end

endmodule
